// File: rtl/writeback_unit.sv
// Write-back stage: selects ALU/PC+4/IMM operands or waits for a memory word,
// formats loads by funct3/addr_lo and issues a single registered register-file write.
module writeback_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  rd,
    input  logic [1:0]  wb_sel,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imm,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic [4:0]  rd_q, rd_next;
    logic [2:0]  funct3_q, funct3_next;
    logic [1:0]  addr_lo_q, addr_lo_next;
    logic        rf_we_next, done_next, err_next;
    logic [4:0]  rf_rd_next;
    logic [31:0] rf_data_next;
    logic [31:0] operand;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic        load_bad;

    always_comb begin
        case (wb_sel)
            2'b10:   operand = pc_plus4;
            2'b11:   operand = imm;
            default: operand = alu_result;
        endcase
    end

    // Shifting the selected lane down to bit 0 serves both byte and halfword loads.
    always_comb begin
        lane      = mem_rdata >> {addr_lo_q, 3'b000};
        load_data = mem_rdata;
        load_bad  = 1'b0;
        case (funct3_q)
            3'b000: load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001: begin
                load_data = {{16{lane[15]}}, lane[15:0]};
                load_bad  = addr_lo_q[0];
            end
            3'b010: load_bad = (addr_lo_q != 2'b00);
            3'b100: load_data = {24'd0, lane[7:0]};
            3'b101: begin
                load_data = {16'd0, lane[15:0]};
                load_bad  = addr_lo_q[0];
            end
            default: load_bad = 1'b1;
        endcase
    end

    // Outputs are computed on the transition into WRITE so they are valid for the WRITE cycle.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        rd_next       = rd_q;
        funct3_next   = funct3_q;
        addr_lo_next  = addr_lo_q;
        rf_we_next    = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        rf_rd_next    = rf_rd;
        rf_data_next  = rf_data;
        case (state)
            IDLE: begin
                if (start) begin
                    rd_next      = rd;
                    funct3_next  = funct3;
                    addr_lo_next = addr_lo;
                    if (wb_sel == 2'b01) begin
                        state_next    = WAIT_MEM;
                        wait_cnt_next = '0;
                    end else begin
                        state_next = WRITE;
                        done_next  = 1'b1;
                        if (rd != 5'd0) begin
                            rf_we_next   = 1'b1;
                            rf_rd_next   = rd;
                            rf_data_next = operand;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_valid) begin
                    state_next = WRITE;
                    done_next  = 1'b1;
                    if (load_bad) begin
                        err_next = 1'b1;
                    end else if (rd_q != 5'd0) begin
                        rf_we_next   = 1'b1;
                        rf_rd_next   = rd_q;
                        rf_data_next = load_data;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    state_next = WRITE;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            rd_q      <= rd_next;
            funct3_q  <= funct3_next;
            addr_lo_q <= addr_lo_next;
            rf_we     <= rf_we_next;
            rf_rd     <= rf_rd_next;
            rf_data   <= rf_data_next;
            busy      <= (state_next != IDLE);
            done      <= done_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit: a per-transaction model schedules the expected
// outputs by cycle number and a negedge process compares them every cycle.
module tb_writeback_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  rd = '0;
    logic [1:0]  wb_sel = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] pc_plus4 = '0;
    logic [31:0] imm = '0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  addr_lo = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;
    logic        err;

    writeback_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rd(rd), .wb_sel(wb_sel),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
        .funct3(funct3), .addr_lo(addr_lo), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Scheduled expectation for the current transaction.
    bit          active = 1'b0;
    int unsigned t_bs = 0;
    int unsigned t_dc = 0;
    bit          t_we = 1'b0;
    bit          t_err = 1'b0;
    logic [4:0]  t_rd = '0;
    logic [31:0] t_data = '0;
    logic [4:0]  mdl_rd = '0;
    logic [31:0] mdl_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, exp);
        end
    endtask

    // Returns {bad, data} for a load, straight from the load-type rules.
    function automatic logic [32:0] load_model(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lo);
        int unsigned b, h;
        logic [31:0] d;
        logic bad;
        b = (word >> (8 * lo)) & 32'hFF;
        h = (word >> (16 * (lo / 2))) & 32'hFFFF;
        bad = 1'b0;
        d = word;
        case (f3)
            3'd0: d = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1: begin bad = (lo % 2) != 0; d = (h >= 32768) ? (h | 32'hFFFF_0000) : h; end
            3'd2: bad = (lo != 0);
            3'd4: d = b;
            3'd5: begin bad = (lo % 2) != 0; d = h; end
            default: bad = 1'b1;
        endcase
        return {bad, d};
    endfunction

    always @(negedge clk) begin
        logic e_busy, e_done;
        e_done = active && (cyc == t_dc);
        e_busy = active && (cyc >= t_bs) && (cyc <= t_dc);
        if (e_done && t_we) begin
            mdl_rd   = t_rd;
            mdl_data = t_data;
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("err", err, e_done && t_err);
        check("rf_we", rf_we, e_done && t_we);
        check("rf_rd", rf_rd, mdl_rd);
        check("rf_data", rf_data, mdl_data);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [1:0] sel, input logic [4:0] r, input logic [2:0] f3,
                               input logic [1:0] lo, input logic [31:0] op);
        start      = 1'b1;
        wb_sel     = sel;
        rd         = r;
        funct3     = f3;
        addr_lo    = lo;
        alu_result = $urandom;
        pc_plus4   = $urandom;
        imm        = $urandom;
        case (sel)
            2'b00: alu_result = op;
            2'b10: pc_plus4 = op;
            2'b11: imm = op;
            default: ;
        endcase
        mem_valid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    task automatic scramble_inputs();
        start      = 1'($urandom_range(0, 1));
        wb_sel     = 2'($urandom);
        rd         = 5'($urandom);
        funct3     = 3'($urandom);
        addr_lo    = 2'($urandom);
        alu_result = $urandom;
        pc_plus4   = $urandom;
        imm        = $urandom;
    endtask

    // Called during an IDLE cycle; returns in the cycle where done is expected.
    // vk = WAIT_MEM cycle (1-based) carrying mem_valid; 0 or >TO means never.
    task automatic run_txn(input logic [1:0] sel, input logic [4:0] r, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] op, input logic [31:0] word,
                           input int unsigned vk);
        int unsigned n, k_end;
        bit timed_out;
        logic [32:0] lm;
        drive_start(sel, r, f3, lo, op);
        next_cycle();
        n = cyc;
        scramble_inputs();
        if (sel != 2'b01) begin
            t_bs = n; t_dc = n; t_err = 1'b0; t_we = (r != 0); t_rd = r; t_data = op;
            active = 1'b1;
            mem_valid = 1'($urandom_range(0, 1));
            return;
        end
        timed_out = !(vk >= 1 && vk <= TO);
        k_end = timed_out ? TO : vk;
        lm = load_model(word, f3, lo);
        t_bs = n; t_dc = n + k_end;
        t_err = timed_out || lm[32];
        t_we = !t_err && (r != 0);
        t_rd = r; t_data = lm[31:0];
        active = 1'b1;
        for (int unsigned k = 1; k <= k_end; k++) begin
            mem_valid = (k == vk);
            mem_rdata = (k == vk) ? word : $urandom;
            scramble_inputs();
            next_cycle();
        end
        mem_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic to_idle();
        next_cycle();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        active = 1'b0;
        mdl_rd = '0;
        mdl_data = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        next_cycle();
        next_cycle();
        check("reset_busy", busy, 1'b0);
        check("reset_rf_data", rf_data, 32'h0);
        rst = 1'b0;
        next_cycle();

        run_txn(2'b00, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 0);
        check("alu_we", rf_we, 1'b1);
        check("alu_rd", rf_rd, 32'd5);
        check("alu_data", rf_data, 32'h1234_5678);
        check("alu_done", done, 1'b1);
        to_idle();

        run_txn(2'b01, 5'd3, 3'b000, 2'b11, 32'h0, 32'h80FF_0000, 3);
        check("lb_data", rf_data, 32'hFFFF_FF80);
        check("lb_we", rf_we, 1'b1);
        to_idle();

        run_txn(2'b01, 5'd4, 3'b101, 2'b10, 32'h0, 32'hBEEF_0000, 1);
        check("lhu_data", rf_data, 32'h0000_BEEF);
        to_idle();

        run_txn(2'b01, 5'd7, 3'b010, 2'b01, 32'h0, 32'hDEAD_BEEF, 2);
        check("mis_lw_we", rf_we, 1'b0);
        check("mis_lw_err", err, 1'b1);
        check("mis_lw_data_held", rf_data, 32'h0000_BEEF);
        to_idle();

        run_txn(2'b10, 5'd0, 3'd0, 2'd0, 32'h0000_0104, 32'h0, 0);
        check("x0_we", rf_we, 1'b0);
        check("x0_done", done, 1'b1);
        check("x0_err", err, 1'b0);
        to_idle();

        run_txn(2'b01, 5'd9, 3'b010, 2'b00, 32'h0, 32'h1111_2222, 0);
        check("timeout_err", err, 1'b1);
        check("timeout_we", rf_we, 1'b0);
        to_idle();

        run_txn(2'b01, 5'd10, 3'b010, 2'b00, 32'h0, 32'hCAFE_F00D, TO);
        check("edge_valid_err", err, 1'b0);
        check("edge_valid_data", rf_data, 32'hCAFE_F00D);
        to_idle();

        // Reset while waiting for memory; the late mem_valid must be ignored.
        drive_start(2'b01, 5'd11, 3'b010, 2'b00, 32'h0);
        mem_valid = 1'b0;
        next_cycle();
        start = 1'b0;
        t_bs = cyc; t_dc = 32'hFFFF_FFFF; t_we = 1'b0; t_err = 1'b0;
        active = 1'b1;
        next_cycle();
        apply_reset();
        #1;
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_rf_data", rf_data, 32'h0);
        next_cycle();
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) next_cycle();
        check("rst_no_done", done, 1'b0);
        check("rst_no_we", rf_we, 1'b0);
        mem_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run_txn(2'($urandom), r, 3'($urandom), 2'($urandom), $urandom, $urandom,
                    $urandom_range(0, TO + 2));
            to_idle();
            if ($urandom_range(0, 1) == 1) next_cycle();
        end

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT_MEM cycles before abort (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, write-back request; sampled only in IDLE.
REQ-005 SHALL have port rd, input, 5, destination register index.
REQ-006 SHALL have port wb_sel, input, 2: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-007 SHALL have ports alu_result, pc_plus4 and imm, input, 32 each, source operands.
REQ-008 SHALL have port funct3, input, 3, load type, used only when wb_sel=01.
REQ-009 SHALL have port addr_lo, input, 2, low load-address bits, used only when wb_sel=01.
REQ-010 SHALL have port mem_rdata, input, 32, memory word; sampled only when mem_valid=1 in WAIT_MEM.
REQ-011 SHALL have port mem_valid, input, 1, memory data-valid strobe.
REQ-012 SHALL have port rf_we, output, 1, register-file write enable.
REQ-013 SHALL have port rf_rd, output, 5, register-file write address.
REQ-014 SHALL have port rf_data, output, 32, register-file write data.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-016 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-017 SHALL have port err, output, 1, single-cycle error pulse, coincident with done.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_MEM and WRITE, with all outputs driven from registers.
REQ-019 SHALL, in IDLE with start=1, latch rd, wb_sel, funct3, addr_lo, and the selected operand (alu_result, pc_plus4 or imm).
- next state: WAIT_MEM if wb_sel=01, else WRITE.
REQ-020 SHALL ignore start in any state other than IDLE; no latch, no queueing.
REQ-021 SHALL, in WAIT_MEM with mem_valid=1, capture mem_rdata and go to WRITE.
- mem_valid outside WAIT_MEM: ignored.
REQ-022 SHALL count WAIT_MEM cycles with an 8-bit counter cleared on WAIT_MEM entry.
- count reaches TIMEOUT without mem_valid -> go to WRITE with the timeout flag set.
- mem_valid in the same cycle the count reaches TIMEOUT -> data wins, no timeout.
REQ-023 SHALL format load data by funct3, selecting the byte/halfword lane from addr_lo:
- 000 lb: sign-extend byte.
- 001 lh: sign-extend halfword.
- 010 lw: full word.
- 100 lbu: zero-extend byte.
- 101 lhu: zero-extend halfword.
REQ-024 SHALL treat as an error, with no register write:
- lh/lhu with addr_lo[0]=1.
- lw with addr_lo!=00.
- funct3 011, 110 or 111.
- a timeout.
REQ-025 SHALL, in WRITE, assert done=1 for exactly one cycle, drive rf_rd and rf_data, then return to IDLE.
- rf_we=1 only if no error and rd!=0.
- err=1 if an error was flagged.
REQ-026 SHALL deassert rf_we when rd=0 while still pulsing done, keeping x0 unwritten.
REQ-027 SHALL have latency for non-MEM sources: start accepted at edge N -> rf_we/done high in the cycle after N.
REQ-028 SHALL have latency for MEM sources: mem_valid sampled at edge M -> rf_we/done high in the cycle after M.
REQ-029 SHALL hold rf_rd and rf_data at their last values when rf_we=0.
REQ-030 SHALL accept a new start in the cycle immediately following WRITE, giving back-to-back throughput of one request per 2 cycles for non-MEM sources.

Reset
REQ-031 SHALL, on rst=1 at any time, force the following, taking effect asynchronously:
- state IDLE.
- rf_we=0, rf_rd=0, rf_data=0.
- busy=0, done=0, err=0.
- WAIT_MEM counter=0.
REQ-032 SHALL abort any in-flight request on reset mid-operation, with no subsequent write, done or err for it.

Verification
REQ-033 SHALL be verified by the bench with these directed scenarios:
- ALU write: start, wb_sel=00, rd=5, alu_result=0x1234_5678 -> next cycle rf_we=1, rf_rd=5, rf_data=0x1234_5678, done=1.
- lb: wb_sel=01, funct3=000, addr_lo=11, mem_rdata=0x80FF_0000, mem_valid after 3 cycles -> rf_data=0xFFFF_FF80, rf_we=1.
- lhu: funct3=101, addr_lo=10, mem_rdata=0xBEEF_0000 -> rf_data=0x0000_BEEF.
- Misaligned lw: addr_lo=01, rd=7 -> rf_we=0, done=1, err=1.
- x0 target: rd=0, wb_sel=10, pc_plus4=0x104 -> rf_we=0, done=1, err=0.
- Timeout: TIMEOUT=4, mem_valid never asserted -> err=1 and done=1, rf_we=0.
- Reset in WAIT_MEM: rst pulse, then mem_valid=1 -> busy=0, no done, no rf_we.
